vga_render_multi: RTL and testbench
===================================

// Module: vga_render_multi
// PURPOSE
//  Parametrised successor to the fixed 4-obstacle VGA output stage: renders bird + NUM_OBST pipe
//  obstacles onto a 640x480 VGA raster with multi-bit colour. Adds a tear-free shadow latch,
//  a pixel-enable divider, an aligned 2-stage pixel pipeline and a frame_tick to pace game logic.
//  Sits between the game-state logic (positions) and the board VGA pins.
// PARAMETERS
//  NUM_OBST     4    number of obstacles (1..8)
//  COLOR_BITS   1    bits per colour channel (1..4)
//  CLK_DIV      2    clk cycles per pixel (1..4); 50 MHz/2 = 25 MHz pixel rate
//  BIRD_SIZE    16   bird square side, pixels
//  OBST_WIDTH   40   obstacle column width, pixels
//  GAP_HEIGHT   100  vertical opening in each obstacle, pixels
//  SYNC_POL     0    sync active level (0 = active-low, VGA 640x480 standard)
// PORTS
//  clk         in   1               system clock
//  reset       in   1               asynchronous, active-low reset
//  BirdXdraw   in   10              bird left edge, pixels
//  BirdYdraw   in   10              bird top edge, pixels
//  X_Edge_O    in   10*NUM_OBST     packed obstacle left edges; obstacle i = [10*i+9:10*i]
//  Y_Edge_O    in   10*NUM_OBST     packed obstacle gap top edges
//  vga_h_sync  out  1               horizontal sync
//  vga_v_sync  out  1               vertical sync
//  vga_r       out  COLOR_BITS      red
//  vga_g       out  COLOR_BITS      green
//  vga_b       out  COLOR_BITS      blue
//  frame_tick  out  1               one-clk pulse at start of vertical blanking
// BEHAVIOUR
//  Reset (async, reset==0): counters 0, divider 0, syncs at inactive level (~SYNC_POL),
//   colours 0, frame_tick 0, shadow X/Y/bird regs = 10'h3FF (everything off-screen).
//  pix_en: divider counts 0..CLK_DIV-1; pix_en=1 on the cycle it equals CLK_DIV-1 (CLK_DIV=1: always).
//   All raster state advances only on pix_en.
//  Timing: h 0..799 (active 0-639, FP 640-655, sync 656-751, BP 752-799);
//   v 0..524 (active 0-479, FP 480-489, sync 490-491, BP 492-524). h wraps 799->0 and
//   increments v; v wraps 524->0 when h wraps.
//  Shadow latch: on pix_en with h==0, v==480 all position inputs are sampled into shadow regs;
//   rendering uses shadow regs only, so mid-frame input changes never tear. frame_tick=1 that cycle.
//  Hit tests (11-bit arithmetic, no wrap): bird hit iff BX<=h<BX+BIRD_SIZE and BY<=v<BY+BIRD_SIZE.
//   Obstacle i hit iff Xi<=h<Xi+OBST_WIDTH and NOT (Yi<=v<Yi+GAP_HEIGHT). Any edge >=640
//   with its extent clipped at 639; Xi>=640 draws nothing.
//  Priority: bird (yellow: R,G max, B 0) > any obstacle (green: G max) > background
//   (cyan: G,B max, R 0). Outside active area colours forced to 0 (blanking).
//  Pipeline: stage1 registers hit flags + active + raw syncs; stage2 registers colours + syncs.
//   Latency: raster position (h,v) appears on all outputs exactly 2 pix_en later; sync and
//   colour always mutually aligned. Outputs hold between pix_en.
//  Reset mid-frame: immediate return to reset values; raster restarts at h=0,v=0 after release.
// STRUCTURE
//  vga_pkg: H_/V_ timing constants (ACTIVE, FP, SYNC, BP, TOTAL), colour index constants.
//  Sub-module vga_timing_gen: divider, h/v counters, raw syncs, active flag, pix_en, frame_tick.
//  Top: shadow regs, generate-loop obstacle comparators, OR-reduce, priority mux, pipeline.
// TESTING
//  1 Reset low 100 ns then release -> syncs high, colours 0 until first active pixel; h period
//    800 pix_en, v period 525 lines; vga_h_sync low for exactly 96 pixels at h=656..751.
//  2 Bird=(320,240), all obstacles X=1023 -> output pixel (320..335,240..255) yellow, all other
//    active pixels cyan; first yellow pixel 2 pix_en after h=320,v=240.
//  3 X_Edge_O={300,200,100,10}, Y_Edge_O={300,200,100,10} -> obstacle 1 green at x 100..139
//    except y 100..199; overlap with bird at (320,240) shows yellow.
//  4 Change BirdXdraw 320->100 at v=100 -> current frame still draws at 320; next frame at 100;
//    frame_tick one clk wide, once per 525 lines.
//  5 X_Edge_O1=620 -> green for x 620..639 only, blank from 640; X=640 -> no green.
//  6 CLK_DIV=1, COLOR_BITS=4, NUM_OBST=8 -> same raster at full rate, 4'hF channel values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, colour indices and span helper
// for the multi-obstacle render stage.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] POS_OFF = 10'h3FF;

  typedef enum logic [1:0] {
    COL_BG    = 2'd0,
    COL_OBST  = 2'd1,
    COL_BIRD  = 2'd2,
    COL_BLANK = 2'd3
  } color_idx_e;

  // 11-bit so that an edge near 1023 plus its extent never wraps
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus h/v raster counters; derives raw sync flags,
// the active-area flag and the start-of-vertical-blanking tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int H_ACT_PIX    = H_ACTIVE,
  parameter int H_FP_PIX     = H_FP,
  parameter int H_SYNC_PIX   = H_SYNC,
  parameter int H_BP_PIX     = H_BP,
  parameter int V_ACT_LINES  = V_ACTIVE,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       h_in_sync,
  output logic       v_in_sync,
  output logic       active,
  output logic       frame_tick
);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACT_PIX + H_FP_PIX + H_SYNC_PIX + H_BP_PIX - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACT_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACT_PIX);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACT_PIX + H_FP_PIX);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACT_PIX + H_FP_PIX + H_SYNC_PIX);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACT_LINES);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACT_LINES + V_FP_LINES);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACT_LINES + V_FP_LINES + V_SYNC_LINES);

  logic [1:0] div_cnt;

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so pix_en is constant high
  assign pix_en     = (div_cnt == DIV_LAST);
  assign h_in_sync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign active     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign frame_tick = pix_en && (h_cnt == 10'd0) && (v_cnt == V_ACT_END);

  // Divider and raster counters; raster moves only on pix_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= 2'd0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
    end else begin
      div_cnt <= pix_en ? 2'd0 : div_cnt + 2'd1;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_render_multi.sv
// Renders bird + NUM_OBST pipe obstacles onto the VGA raster from shadow
// copies of the positions, through an aligned two-stage pixel pipeline.
module vga_render_multi
  import vga_pkg::*;
#(
  parameter int NUM_OBST     = 4,
  parameter int COLOR_BITS   = 1,
  parameter int CLK_DIV      = 2,
  parameter int BIRD_SIZE    = 16,
  parameter int OBST_WIDTH   = 40,
  parameter int GAP_HEIGHT   = 100,
  parameter bit SYNC_POL     = 1'b0,
  parameter int H_ACT_PIX    = H_ACTIVE,
  parameter int H_FP_PIX     = H_FP,
  parameter int H_SYNC_PIX   = H_SYNC,
  parameter int H_BP_PIX     = H_BP,
  parameter int V_ACT_LINES  = V_ACTIVE,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              BirdXdraw,
  input  logic [9:0]              BirdYdraw,
  input  logic [10*NUM_OBST-1:0]  X_Edge_O,
  input  logic [10*NUM_OBST-1:0]  Y_Edge_O,
  output logic                    vga_h_sync,
  output logic                    vga_v_sync,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    frame_tick
);

  localparam logic [10:0] BIRD_LEN = 11'(BIRD_SIZE);
  localparam logic [10:0] OBST_LEN = 11'(OBST_WIDTH);
  localparam logic [10:0] GAP_LEN  = 11'(GAP_HEIGHT);
  localparam logic [COLOR_BITS-1:0] C_MAX  = '1;
  localparam logic [COLOR_BITS-1:0] C_ZERO = '0;

  logic       pix_en, h_in_sync, v_in_sync, active;
  logic [9:0] h_cnt, v_cnt;
  logic [10:0] h_pos, v_pos;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV),
    .H_ACT_PIX(H_ACT_PIX), .H_FP_PIX(H_FP_PIX), .H_SYNC_PIX(H_SYNC_PIX), .H_BP_PIX(H_BP_PIX),
    .V_ACT_LINES(V_ACT_LINES), .V_FP_LINES(V_FP_LINES),
    .V_SYNC_LINES(V_SYNC_LINES), .V_BP_LINES(V_BP_LINES)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_in_sync(h_in_sync), .v_in_sync(v_in_sync), .active(active),
    .frame_tick(frame_tick)
  );

  assign h_pos = {1'b0, h_cnt};
  assign v_pos = {1'b0, v_cnt};

  logic [9:0]             bird_x_sh, bird_y_sh;
  logic [10*NUM_OBST-1:0] obst_x_sh, obst_y_sh;

  // Positions are captured once per frame at the start of vertical blanking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bird_x_sh <= POS_OFF;
      bird_y_sh <= POS_OFF;
      obst_x_sh <= {NUM_OBST{POS_OFF}};
      obst_y_sh <= {NUM_OBST{POS_OFF}};
    end else if (frame_tick) begin
      bird_x_sh <= BirdXdraw;
      bird_y_sh <= BirdYdraw;
      obst_x_sh <= X_Edge_O;
      obst_y_sh <= Y_Edge_O;
    end
  end

  logic                bird_hit, obst_any;
  logic [NUM_OBST-1:0] obst_hit;

  assign bird_hit = in_span(h_pos, {1'b0, bird_x_sh}, BIRD_LEN) &&
                    in_span(v_pos, {1'b0, bird_y_sh}, BIRD_LEN);

  for (genvar i = 0; i < NUM_OBST; i++) begin : g_obst
    assign obst_hit[i] = in_span(h_pos, {1'b0, obst_x_sh[10*i +: 10]}, OBST_LEN) &&
                         !in_span(v_pos, {1'b0, obst_y_sh[10*i +: 10]}, GAP_LEN);
  end

  assign obst_any = |obst_hit;

  logic s1_bird, s1_obst, s1_active, s1_hs, s1_vs;

  // Stage 1: hit flags and raw syncs for the current raster position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_bird   <= 1'b0;
      s1_obst   <= 1'b0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else if (pix_en) begin
      s1_bird   <= bird_hit;
      s1_obst   <= obst_any;
      s1_active <= active;
      s1_hs     <= h_in_sync;
      s1_vs     <= v_in_sync;
    end
  end

  color_idx_e col_idx;
  logic [COLOR_BITS-1:0] r_nxt, g_nxt, b_nxt;

  always_comb begin
    if (!s1_active)    col_idx = COL_BLANK;
    else if (s1_bird)  col_idx = COL_BIRD;
    else if (s1_obst)  col_idx = COL_OBST;
    else               col_idx = COL_BG;
  end

  always_comb begin
    r_nxt = C_ZERO;
    g_nxt = C_ZERO;
    b_nxt = C_ZERO;
    case (col_idx)
      COL_BIRD:  begin r_nxt = C_MAX; g_nxt = C_MAX; end
      COL_OBST:  g_nxt = C_MAX;
      COL_BG:    begin g_nxt = C_MAX; b_nxt = C_MAX; end
      COL_BLANK: r_nxt = C_ZERO;
      default:   r_nxt = C_ZERO;
    endcase
  end

  // Stage 2: colours and polarity-adjusted syncs leave together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r      <= C_ZERO;
      vga_g      <= C_ZERO;
      vga_b      <= C_ZERO;
      vga_h_sync <= ~SYNC_POL;
      vga_v_sync <= ~SYNC_POL;
    end else if (pix_en) begin
      vga_r      <= r_nxt;
      vga_g      <= g_nxt;
      vga_b      <= b_nxt;
      vga_h_sync <= s1_hs ? SYNC_POL : ~SYNC_POL;
      vga_v_sync <= s1_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_render_multi.sv
// Directed bench: a full-timing default instance and a shrunken-raster
// instance (CLK_DIV=1, 4-bit colour, 8 obstacles) driven from one sequence.
module tb_vga_render_multi;

  localparam int SH = 80;          // small raster: 64+4+8+4 pixels per line
  localparam int SF = 80 * 56;     // small raster: 48+2+2+4 lines per frame

  localparam logic [11:0] S_YEL = 12'hFF0;
  localparam logic [11:0] S_GRN = 12'h0F0;
  localparam logic [11:0] S_CYN = 12'h0FF;
  localparam logic [11:0] S_BLK = 12'h000;
  localparam logic [2:0]  F_CYN = 3'b011;
  localparam logic [2:0]  F_BLK = 3'b000;

  logic clk;
  logic rst_n;

  logic [9:0]  f_bx, f_by;
  logic [39:0] f_xe, f_ye;
  logic        f_hs, f_vs, f_ft;
  logic        f_r, f_g, f_b;

  logic [9:0]  s_bx, s_by;
  logic [79:0] s_xe, s_ye;
  logic        s_hs, s_vs, s_ft;
  logic [3:0]  s_r, s_g, s_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lows  = 0;

  vga_render_multi u_full (
    .clk(clk), .reset(rst_n),
    .BirdXdraw(f_bx), .BirdYdraw(f_by), .X_Edge_O(f_xe), .Y_Edge_O(f_ye),
    .vga_h_sync(f_hs), .vga_v_sync(f_vs),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .frame_tick(f_ft)
  );

  vga_render_multi #(
    .NUM_OBST(8), .COLOR_BITS(4), .CLK_DIV(1),
    .BIRD_SIZE(4), .OBST_WIDTH(8), .GAP_HEIGHT(10), .SYNC_POL(1'b0),
    .H_ACT_PIX(64), .H_FP_PIX(4), .H_SYNC_PIX(8), .H_BP_PIX(4),
    .V_ACT_LINES(48), .V_FP_LINES(2), .V_SYNC_LINES(2), .V_BP_LINES(4)
  ) u_small (
    .clk(clk), .reset(rst_n),
    .BirdXdraw(s_bx), .BirdYdraw(s_by), .X_Edge_O(s_xe), .Y_Edge_O(s_ye),
    .vga_h_sync(s_hs), .vga_v_sync(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .frame_tick(s_ft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic seek(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Small instance: pixel (h,v) of frame f is on the outputs 2 clocks after its raster slot
  task automatic sp(input string tag, input int f, input int h, input int v,
                    input logic [11:0] rgb, input logic hs, input logic vs);
    seek(f * SF + v * SH + h + 2);
    chk(tag, {18'd0, s_r, s_g, s_b, s_hs, s_vs}, {18'd0, rgb, hs, vs});
  endtask

  task automatic fchk(input string tag, input logic [2:0] rgb, input logic hs, input logic vs);
    chk(tag, {27'd0, f_r, f_g, f_b, f_hs, f_vs}, {27'd0, rgb, hs, vs});
  endtask

  initial begin
    rst_n = 1'b0;
    f_bx = 10'd320; f_by = 10'd240;
    f_xe = {10'd300, 10'd200, 10'd100, 10'd10};
    f_ye = {10'd300, 10'd200, 10'd100, 10'd10};
    s_bx = 10'd32;  s_by = 10'd24;
    s_xe = {10'd1023, 10'd1023, 10'd1023, 10'd30, 10'd64, 10'd60, 10'd10, 10'd2};
    s_ye = {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd40, 10'd10, 10'd2};

    #50;
    chk("rst_small", {16'd0, s_r, s_g, s_b, s_hs, s_vs, s_ft}, {16'd0, 12'h000, 1'b1, 1'b1, 1'b0});
    chk("rst_full", {24'd0, f_r, f_g, f_b, f_hs, f_vs, f_ft}, {24'd0, 3'b000, 1'b1, 1'b1, 1'b0});
    #50;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Frame 0: shadow still off-screen, so no bird or obstacles anywhere
    seek(1);
    chk("s_pipe_fill", {18'd0, s_r, s_g, s_b, s_hs, s_vs}, {18'd0, S_BLK, 1'b1, 1'b1});
    sp("s_f0_origin",   0, 0,  0,  S_CYN, 1'b1, 1'b1);
    sp("s_f0_fp",       0, 67, 0,  S_BLK, 1'b1, 1'b1);
    sp("s_f0_hs_first", 0, 68, 0,  S_BLK, 1'b0, 1'b1);
    sp("s_f0_hs_last",  0, 75, 0,  S_BLK, 1'b0, 1'b1);
    sp("s_f0_bp",       0, 76, 0,  S_BLK, 1'b1, 1'b1);
    sp("s_f0_no_bird",  0, 32, 24, S_CYN, 1'b1, 1'b1);

    seek(48 * SH - 1);
    chk("s_ftick_pre", {31'd0, s_ft}, 32'd0);
    tick();
    chk("s_ftick", {31'd0, s_ft}, 32'd1);
    tick();
    chk("s_ftick_post", {31'd0, s_ft}, 32'd0);

    sp("s_f0_vs",      0, 0, 50, S_BLK, 1'b1, 1'b0);
    sp("s_f0_vs_end",  0, 0, 52, S_BLK, 1'b1, 1'b1);

    // Frame 1: shadow holds the positions set before the tick
    sp("s_obst0",      1, 9,  0,  S_GRN, 1'b1, 1'b1);
    sp("s_obst2_clip", 1, 63, 0,  S_GRN, 1'b1, 1'b1);
    sp("s_clip_blank", 1, 64, 0,  S_BLK, 1'b1, 1'b1);
    sp("s_obst0_gap",  1, 9,  5,  S_CYN, 1'b1, 1'b1);
    sp("s_obst1_left", 1, 10, 5,  S_GRN, 1'b1, 1'b1);
    sp("s_obst1_rght", 1, 17, 5,  S_GRN, 1'b1, 1'b1);
    sp("s_obst1_past", 1, 18, 5,  S_CYN, 1'b1, 1'b1);
    sp("s_gap_top",    1, 10, 10, S_CYN, 1'b1, 1'b1);
    sp("s_gap_bot",    1, 10, 19, S_CYN, 1'b1, 1'b1);
    sp("s_gap_below",  1, 10, 20, S_GRN, 1'b1, 1'b1);
    sp("s_obst4_l",    1, 31, 24, S_GRN, 1'b1, 1'b1);
    sp("s_bird_tl",    1, 32, 24, S_YEL, 1'b1, 1'b1);
    sp("s_obst4_r",    1, 36, 24, S_GRN, 1'b1, 1'b1);
    sp("s_bg",         1, 38, 24, S_CYN, 1'b1, 1'b1);
    sp("s_bird_br",    1, 35, 27, S_YEL, 1'b1, 1'b1);

    seek(SF + 30 * SH + 2);
    s_bx = 10'd10;
    s_xe[49:40] = 10'd1023;
    sp("s_no_tear",    1, 31, 35, S_GRN, 1'b1, 1'b1);

    seek(SF + 48 * SH - 1);
    chk("s_ftick2_pre", {31'd0, s_ft}, 32'd0);
    tick();
    chk("s_ftick2", {31'd0, s_ft}, 32'd1);

    // Frame 2: new bird position, obstacle 4 gone
    sp("s_f2_bird",    2, 10, 24, S_YEL, 1'b1, 1'b1);
    sp("s_f2_oldbird", 2, 32, 24, S_CYN, 1'b1, 1'b1);
    sp("s_f2_obst4",   2, 31, 35, S_CYN, 1'b1, 1'b1);

    // Mid-frame reset returns everything to reset values at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_small", {16'd0, s_r, s_g, s_b, s_hs, s_vs, s_ft}, {16'd0, 12'h000, 1'b1, 1'b1, 1'b0});
    chk("mid_rst_full", {24'd0, f_r, f_g, f_b, f_hs, f_vs, f_ft}, {24'd0, 3'b000, 1'b1, 1'b1, 1'b0});
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    sp("s_restart",    0, 0, 0, S_CYN, 1'b1, 1'b1);
    seek(3);
    fchk("f_pipe_fill", F_BLK, 1'b1, 1'b1);

    // Full-timing line 0: pixel p shows after clock 2p+4
    for (int p = 0; p < 800; p++) begin
      seek(2 * p + 4);
      if (f_hs == 1'b0) lows++;
      case (p)
        0:   fchk("f_origin",   F_CYN, 1'b1, 1'b1);
        639: begin
          fchk("f_last_act", F_CYN, 1'b1, 1'b1);
          tick();
          fchk("f_hold",     F_CYN, 1'b1, 1'b1);
        end
        640: fchk("f_blank",    F_BLK, 1'b1, 1'b1);
        655: fchk("f_fp_end",   F_BLK, 1'b1, 1'b1);
        656: fchk("f_hs_first", F_BLK, 1'b0, 1'b1);
        751: fchk("f_hs_last",  F_BLK, 1'b0, 1'b1);
        752: fchk("f_bp",       F_BLK, 1'b1, 1'b1);
        799: fchk("f_line_end", F_BLK, 1'b1, 1'b1);
        default: ;
      endcase
    end
    chk("f_hs_width", lows, 32'd96);

    seek(2 * 800 + 4);
    fchk("f_line1", F_CYN, 1'b1, 1'b1);
    sp("s_rst_shadow", 0, 10, 24, S_CYN, 1'b1, 1'b1);
    seek(2 * 1456 + 4);
    fchk("f_line1_hs", F_BLK, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
